// File: rtl/fft16_pkg.sv
// Shared constants, complex word type and helpers for the 16-point FFT datapath.
package fft16_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 17;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Per-bank occupancy as tracked by the framer.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// 16-entry complex register bank: one indexed write port, every entry readable in parallel.
module fft16_frame_bank
  import fft16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [LOG2N-1:0]      wr_idx,
  input  logic [2*DW-1:0]       wr_data,
  output logic [N*2*DW-1:0]     rd_data
);

  logic [2*DW-1:0] mem [N];

  // NOTE: this storage takes the async reset because a freshly reset bank must read as all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_rd
    assign rd_data[k*2*DW +: 2*DW] = mem[k];
  end

endmodule

// File: rtl/fft16_input_framer.sv
// Serial-to-frame packer for the 16-point FFT: ping-pong banks with valid/ready on both sides.
// Define FFT16_BITREV_EN to store samples in bit-reversed order for the DIT butterfly chain.
module fft16_input_framer
  import fft16_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW-1:0]   data_o0_R,  data_o0_I,
  output logic signed [DW-1:0]   data_o1_R,  data_o1_I,
  output logic signed [DW-1:0]   data_o2_R,  data_o2_I,
  output logic signed [DW-1:0]   data_o3_R,  data_o3_I,
  output logic signed [DW-1:0]   data_o4_R,  data_o4_I,
  output logic signed [DW-1:0]   data_o5_R,  data_o5_I,
  output logic signed [DW-1:0]   data_o6_R,  data_o6_I,
  output logic signed [DW-1:0]   data_o7_R,  data_o7_I,
  output logic signed [DW-1:0]   data_o8_R,  data_o8_I,
  output logic signed [DW-1:0]   data_o9_R,  data_o9_I,
  output logic signed [DW-1:0]   data_o10_R, data_o10_I,
  output logic signed [DW-1:0]   data_o11_R, data_o11_I,
  output logic signed [DW-1:0]   data_o12_R, data_o12_I,
  output logic signed [DW-1:0]   data_o13_R, data_o13_I,
  output logic signed [DW-1:0]   data_o14_R, data_o14_I,
  output logic signed [DW-1:0]   data_o15_R, data_o15_I,
  output logic                   frame_err
);

  logic [LOG2N-1:0]     wptr, wptr_nxt;
  logic                 wbank, wbank_nxt;
  logic                 rbank, rbank_nxt;
  logic [1:0]           bank_full, bank_full_nxt;
  logic                 wr_fire, rd_fire, sof_restart;
  logic [LOG2N-1:0]     slot, wr_idx;
  logic signed [DW-1:0] re_ext, im_ext;
  logic [N*2*DW-1:0]    bank_rd [2];
  cplx_t                frame [N];

  assign in_ready  = (bank_full[wbank] == BANK_EMPTY);
  assign out_valid = (bank_full[rbank] == BANK_FULL);

  assign wr_fire     = in_valid && in_ready;
  assign rd_fire     = out_valid && out_ready;
  assign sof_restart = wr_fire && in_sof && (wptr != '0);
  // A mid-frame start-of-frame rewinds the write slot so the new sample lands first.
  assign slot        = sof_restart ? '0 : wptr;

`ifdef FFT16_BITREV_EN
  assign wr_idx = bitrev4(slot);
`else
  assign wr_idx = slot;
`endif

  assign re_ext = DW'(in_re);
  assign im_ext = DW'(in_im);

  // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    wptr_nxt      = wptr;
    wbank_nxt     = wbank;
    rbank_nxt     = rbank;
    bank_full_nxt = bank_full;
    if (wr_fire) begin
      wptr_nxt = slot + 1'b1;
      if (slot == LOG2N'(N-1)) begin
        bank_full_nxt[wbank] = BANK_FULL;
        wbank_nxt            = ~wbank;
      end
    end
    // Completion needs an empty write bank and acceptance a full read bank, so these never collide.
    if (rd_fire) begin
      bank_full_nxt[rbank] = BANK_EMPTY;
      rbank_nxt            = ~rbank;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      bank_full <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      wbank     <= wbank_nxt;
      rbank     <= rbank_nxt;
      bank_full <= bank_full_nxt;
      frame_err <= sof_restart;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft16_frame_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire && (wbank == 1'(b))),
      .wr_idx  (wr_idx),
      .wr_data ({re_ext, im_ext}),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      frame[k] = '0;
      if (out_valid) frame[k] = bank_rd[rbank][k*2*DW +: 2*DW];
    end
  end

  assign data_o0_R  = frame[0].re;   assign data_o0_I  = frame[0].im;
  assign data_o1_R  = frame[1].re;   assign data_o1_I  = frame[1].im;
  assign data_o2_R  = frame[2].re;   assign data_o2_I  = frame[2].im;
  assign data_o3_R  = frame[3].re;   assign data_o3_I  = frame[3].im;
  assign data_o4_R  = frame[4].re;   assign data_o4_I  = frame[4].im;
  assign data_o5_R  = frame[5].re;   assign data_o5_I  = frame[5].im;
  assign data_o6_R  = frame[6].re;   assign data_o6_I  = frame[6].im;
  assign data_o7_R  = frame[7].re;   assign data_o7_I  = frame[7].im;
  assign data_o8_R  = frame[8].re;   assign data_o8_I  = frame[8].im;
  assign data_o9_R  = frame[9].re;   assign data_o9_I  = frame[9].im;
  assign data_o10_R = frame[10].re;  assign data_o10_I = frame[10].im;
  assign data_o11_R = frame[11].re;  assign data_o11_I = frame[11].im;
  assign data_o12_R = frame[12].re;  assign data_o12_I = frame[12].im;
  assign data_o13_R = frame[13].re;  assign data_o13_I = frame[13].im;
  assign data_o14_R = frame[14].re;  assign data_o14_I = frame[14].im;
  assign data_o15_R = frame[15].re;  assign data_o15_I = frame[15].im;

endmodule

// File: tb/tb_fft16_input_framer.sv
// Directed and randomized bench for fft16_input_framer; honours FFT16_BITREV_EN for word placement.
module tb_fft16_input_framer;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_sof, out_ready;
  logic [15:0] in_re, in_im;
  wire in_ready, out_valid, frame_err;
  wire [16:0] a_re [16];
  wire [16:0] a_im [16];

  logic b_valid, b_sof, b_ordy;
  logic [7:0] b_re, b_im;
  wire b_irdy, b_ov, b_err;
  wire [16:0] b8_re [16];
  wire [16:0] b8_im [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft16_input_framer #(.IN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .data_o0_R(a_re[0]),   .data_o0_I(a_im[0]),   .data_o1_R(a_re[1]),   .data_o1_I(a_im[1]),
    .data_o2_R(a_re[2]),   .data_o2_I(a_im[2]),   .data_o3_R(a_re[3]),   .data_o3_I(a_im[3]),
    .data_o4_R(a_re[4]),   .data_o4_I(a_im[4]),   .data_o5_R(a_re[5]),   .data_o5_I(a_im[5]),
    .data_o6_R(a_re[6]),   .data_o6_I(a_im[6]),   .data_o7_R(a_re[7]),   .data_o7_I(a_im[7]),
    .data_o8_R(a_re[8]),   .data_o8_I(a_im[8]),   .data_o9_R(a_re[9]),   .data_o9_I(a_im[9]),
    .data_o10_R(a_re[10]), .data_o10_I(a_im[10]), .data_o11_R(a_re[11]), .data_o11_I(a_im[11]),
    .data_o12_R(a_re[12]), .data_o12_I(a_im[12]), .data_o13_R(a_re[13]), .data_o13_I(a_im[13]),
    .data_o14_R(a_re[14]), .data_o14_I(a_im[14]), .data_o15_R(a_re[15]), .data_o15_I(a_im[15]),
    .frame_err(frame_err)
  );

  fft16_input_framer #(.IN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_irdy), .in_sof(b_sof),
    .in_re(b_re), .in_im(b_im), .out_valid(b_ov), .out_ready(b_ordy),
    .data_o0_R(b8_re[0]),   .data_o0_I(b8_im[0]),   .data_o1_R(b8_re[1]),   .data_o1_I(b8_im[1]),
    .data_o2_R(b8_re[2]),   .data_o2_I(b8_im[2]),   .data_o3_R(b8_re[3]),   .data_o3_I(b8_im[3]),
    .data_o4_R(b8_re[4]),   .data_o4_I(b8_im[4]),   .data_o5_R(b8_re[5]),   .data_o5_I(b8_im[5]),
    .data_o6_R(b8_re[6]),   .data_o6_I(b8_im[6]),   .data_o7_R(b8_re[7]),   .data_o7_I(b8_im[7]),
    .data_o8_R(b8_re[8]),   .data_o8_I(b8_im[8]),   .data_o9_R(b8_re[9]),   .data_o9_I(b8_im[9]),
    .data_o10_R(b8_re[10]), .data_o10_I(b8_im[10]), .data_o11_R(b8_re[11]), .data_o11_I(b8_im[11]),
    .data_o12_R(b8_re[12]), .data_o12_I(b8_im[12]), .data_o13_R(b8_re[13]), .data_o13_I(b8_im[13]),
    .data_o14_R(b8_re[14]), .data_o14_I(b8_im[14]), .data_o15_R(b8_re[15]), .data_o15_I(b8_im[15]),
    .frame_err(b_err)
  );

  // Output word position of the n-th sample of a frame.
  function automatic int pos(input int n);
`ifdef FFT16_BITREV_EN
    return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
`else
    return n;
`endif
  endfunction

  function automatic logic [16:0] ext16(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic [15:0] bp_re(input int s);
    return 16'(s * 37 - 500);
  endfunction

  function automatic logic [15:0] bp_im(input int s);
    return 16'(300 - s * 11);
  endfunction

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    b_valid = 1'b0; b_sof = 1'b0; b_re = '0; b_im = '0; b_ordy = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    bad = 0;
    for (int k = 0; k < 16; k++) if (a_re[k] !== 17'd0 || a_im[k] !== 17'd0) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL reset_data: %0d nonzero words, expected 0", bad); end
    rst_n = 1'b1;
    b_ordy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int bad, k5, k8;
`ifdef FFT16_BITREV_EN
    k5 = 10; k8 = 1;
`else
    k5 = 5;  k8 = 8;
`endif
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1; in_re = 16'(n); in_im = 16'(-n);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d]: got %b expected 1", n, in_ready); end
      @(negedge clk);
      n_vec++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL basic_frame_err[%0d]: got %b expected 0", n, frame_err); end
      n_vec++;
      if (out_valid !== (n == 15)) begin
        n_err++; $display("FAIL basic_out_valid[%0d]: got %b expected %b", n, out_valid, (n == 15));
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (a_re[k5] !== 17'd5) begin n_err++; $display("FAIL basic_word5_re: got %0d expected 5", $signed(a_re[k5])); end
    n_vec++;
    if (a_im[k5] !== 17'h1FFFB) begin n_err++; $display("FAIL basic_word5_im: got %0d expected -5", $signed(a_im[k5])); end
    n_vec++;
    if (a_re[k8] !== 17'd8) begin n_err++; $display("FAIL basic_word8_re: got %0d expected 8", $signed(a_re[k8])); end
    bad = 0;
    for (int n = 0; n < 16; n++)
      if (a_re[pos(n)] !== ext16(16'(n)) || a_im[pos(n)] !== ext16(16'(-n))) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL basic_frame: %0d words wrong, expected 0", bad); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: out_valid got %b expected 0", out_valid); end
    n_vec++;
    if (a_re[k5] !== 17'd0) begin n_err++; $display("FAIL basic_zero_data: got %0d expected 0", $signed(a_re[k5])); end
  endtask

  task automatic test_back_to_back();
    int s, cyc, bad;
    logic acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    s = 0; cyc = 0;
    while (s < 32 && cyc < 100) begin
      in_re = bp_re(s); in_im = bp_im(s); acc = in_ready;
      @(negedge clk);
      if (acc) s++;
      cyc++;
    end
    n_vec++;
    if (cyc != 32) begin n_err++; $display("FAIL bp_fill_cycles: got %0d expected 32", cyc); end
    in_re = bp_re(32); in_im = bp_im(32);
    for (int h = 0; h < 3; h++) begin
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", h, in_ready); end
      n_vec++;
      if (a_re[pos(3)] !== ext16(bp_re(3)) || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %0d expected %0d", h, $signed(a_re[pos(3)]), $signed(bp_re(3)));
      end
      @(negedge clk);
    end
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (a_re[pos(k)] !== ext16(bp_re(k)) || a_im[pos(k)] !== ext16(bp_im(k))) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL bp_frame0: %0d words wrong, expected 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (a_re[pos(k)] !== ext16(bp_re(16 + k)) || a_im[pos(k)] !== ext16(bp_im(16 + k))) bad++;
    n_vec++;
    if (bad != 0 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_frame1: %0d words wrong, expected 0", bad); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
    s = 32; cyc = 0;
    while (s < 48 && cyc < 100) begin
      in_re = bp_re(s); in_im = bp_im(s); acc = in_ready;
      @(negedge clk);
      if (acc) s++;
      cyc++;
    end
    n_vec++;
    if (cyc != 16) begin n_err++; $display("FAIL bp_refill_cycles: got %0d expected 16", cyc); end
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_again: in_ready got %b expected 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (a_re[pos(k)] !== ext16(bp_re(32 + k)) || a_im[pos(k)] !== ext16(bp_im(32 + k))) bad++;
    n_vec++;
    if (bad != 0 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_frame2: %0d words wrong, expected 0", bad); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_sof();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_re = 16'(i + 1); in_im = 16'(-(i + 1));
      @(negedge clk);
      n_vec++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL sof_pre[%0d]: frame_err got %b expected 0", i, frame_err); end
    end
    in_valid = 1'b0; in_sof = 1'b1;
    @(negedge clk);
    n_vec++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL sof_no_valid: frame_err got %b expected 0", frame_err); end
    in_valid = 1'b1; in_re = 16'd100; in_im = 16'(-100);
    @(negedge clk);
    in_sof = 1'b0;
    n_vec++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL sof_pulse: frame_err got %b expected 1", frame_err); end
    for (int j = 1; j < 16; j++) begin
      in_re = 16'(100 + j); in_im = 16'(-(100 + j));
      @(negedge clk);
      if (j == 1) begin
        n_vec++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL sof_pulse_width: frame_err got %b expected 0", frame_err); end
      end
      n_vec++;
      if (out_valid !== (j == 15)) begin
        n_err++; $display("FAIL sof_out_valid[%0d]: got %b expected %b", j, out_valid, (j == 15));
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (a_re[0] !== 17'd100) begin n_err++; $display("FAIL sof_word0_re: got %0d expected 100", $signed(a_re[0])); end
    n_vec++;
    if (a_im[0] !== 17'h1FF9C) begin n_err++; $display("FAIL sof_word0_im: got %0d expected -100", $signed(a_im[0])); end
    n_vec++;
    if (a_re[pos(15)] !== 17'd115) begin n_err++; $display("FAIL sof_word15_re: got %0d expected 115", $signed(a_re[pos(15)])); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL sof_consumed: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_sign_ext();
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_re = (i == 0) ? 8'h80 : 8'(i);
      b_im = (i == 0) ? 8'h7F : 8'hFF;
      @(negedge clk);
    end
    b_valid = 1'b0;
    n_vec++;
    if (b_ov !== 1'b1) begin n_err++; $display("FAIL sx_out_valid: got %b expected 1", b_ov); end
    n_vec++;
    if (b8_re[0] !== 17'h1FF80) begin n_err++; $display("FAIL sx_word0_re: got %h expected 1ff80", b8_re[0]); end
    n_vec++;
    if (b8_im[0] !== 17'h0007F) begin n_err++; $display("FAIL sx_word0_im: got %h expected 0007f", b8_im[0]); end
    n_vec++;
    if (b8_im[pos(1)] !== 17'h1FFFF) begin n_err++; $display("FAIL sx_word1_im: got %h expected 1ffff", b8_im[pos(1)]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    out_ready = 1'b0;
    for (int s = 0; s < 25; s++) begin
      in_valid = 1'b1; in_re = 16'(2000 + s); in_im = 16'(-s);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready[%0d]: got %b expected 1", s, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_async_valid: got %b expected 0", out_valid); end
    bad = 0;
    for (int k = 0; k < 16; k++) if (a_re[k] !== 17'd0 || a_im[k] !== 17'd0) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL rm_async_data: %0d nonzero words, expected 0", bad); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      in_valid = 1'b1; in_re = 16'(-5 * s); in_im = 16'(7 * s + 1);
      @(negedge clk);
      n_vec++;
      if (out_valid !== (s == 15)) begin
        n_err++; $display("FAIL rm_out_valid[%0d]: got %b expected %b", s, out_valid, (s == 15));
      end
    end
    in_valid = 1'b0;
    bad = 0;
    for (int s = 0; s < 16; s++)
      if (a_re[pos(s)] !== ext16(16'(-5 * s)) || a_im[pos(s)] !== ext16(16'(7 * s + 1))) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL rm_fresh_frame: %0d words wrong, expected 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] q_re [$];
    logic [15:0] q_im [$];
    logic [15:0] cur_re [16];
    logic [15:0] cur_im [16];
    logic [16:0] snap_re [16];
    logic [16:0] snap_im [16];
    logic [15:0] rr, ri;
    logic iv, ordy, hold;
    int frames_in, frames_out, cyc, cnt, bad;
    frames_in = 0; frames_out = 0; cyc = 0; cnt = 0; hold = 1'b0;
    while (frames_out < 1000 && cyc < 80000) begin
      iv   = ($urandom_range(0, 3) != 0) && (frames_in < 1000);
      ordy = ($urandom_range(0, 2) == 0);
      rr   = 16'($urandom);
      ri   = 16'($urandom);
      in_valid = iv; in_re = rr; in_im = ri; out_ready = ordy;
      if (hold) begin
        bad = 0;
        if (out_valid !== 1'b1) bad++;
        for (int k = 0; k < 16; k++) if (a_re[k] !== snap_re[k] || a_im[k] !== snap_im[k]) bad++;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL rnd_stable cyc %0d: %0d changes, expected 0", cyc, bad); end
      end
      hold = (out_valid === 1'b1) && !ordy;
      for (int k = 0; k < 16; k++) begin snap_re[k] = a_re[k]; snap_im[k] = a_im[k]; end
      if (out_valid === 1'b1 && ordy) begin
        bad = 0;
        if (q_re.size() < 16) bad = 99;
        else
          for (int k = 0; k < 16; k++) begin
            if (a_re[pos(k)] !== ext16(q_re.pop_front())) bad++;
            if (a_im[pos(k)] !== ext16(q_im.pop_front())) bad++;
          end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL rnd_frame %0d: %0d words wrong, expected 0", frames_out, bad); end
        frames_out++;
      end
      if (iv && in_ready === 1'b1) begin
        cur_re[cnt] = rr; cur_im[cnt] = ri; cnt++;
        if (cnt == 16) begin
          for (int k = 0; k < 16; k++) begin q_re.push_back(cur_re[k]); q_im.push_back(cur_im[k]); end
          cnt = 0; frames_in++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if (frames_out != 1000 || q_re.size() != 0) begin
      n_err++; $display("FAIL rnd_frame_count: got %0d frames (%0d words left) expected 1000", frames_out, q_re.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sof();
    test_sign_ext();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft16_input_framer.md
Name: fft16_input_framer

Overview:
- Upstream front end of the 16-point FFT datapath.
- Accepts a serial stream of complex samples with a valid/ready handshake and packs each group of 16 into a frame.
- Uses a ping-pong pair of frame banks; the frame being presented stays stable while the next one fills.
- Presents each frame as 16 parallel 17-bit signed complex words to the first butterfly stage, with its own valid/ready handshake.

Parameters:
- IN_W, 16, signed input sample width; legal range 2..17; sign-extended to DW.
- DW, 17, output word width; fixed to the datapath width used by all butterfly stages.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  framer can accept a sample this cycle.
- in_sof  in  1  start of frame; qualified by in_valid && in_ready.
- in_re  in  IN_W  signed real part of the sample.
- in_im  in  IN_W  signed imaginary part of the sample.
- out_valid  out  1  a complete frame is presented on data_oK.
- out_ready  in  1  downstream accepts the presented frame.
- data_oK_R  out  DW  signed real part of frame word K, for K=0..15 (16 ports).
- data_oK_I  out  DW  signed imaginary part of frame word K, for K=0..15 (16 ports).
- frame_err  out  1  one-cycle pulse: partial frame discarded because of in_sof.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wptr=0, wbank=0, rbank=0, bank_full=2'b00, all bank contents 0.
  - in_ready=1 once rst_n deasserts; out_valid=0, frame_err=0, all data_oK=0.
  - Reset mid-frame discards any partial frame and any full banks.
- Write side:
  - Write happens when in_valid && in_ready.
  - Sample is sign-extended IN_W->DW and stored at bank[wbank][idx(wptr)]; then wptr increments, wrapping 15->0.
  - When the write with wptr==15 completes: bank_full[wbank] sets and wbank toggles.
  - in_ready = !bank_full[wbank], a registered-state decode with no combinational path from out_ready.
- in_sof handling (on a write):
  - If wptr!=0: the partial frame is dropped, the sample is written at index 0, wptr becomes 1, and frame_err pulses high the next cycle.
  - If wptr==0: in_sof has no effect.
  - in_sof is ignored when in_valid=0.
- Read side:
  - out_valid = bank_full[rbank].
  - On out_valid && out_ready: bank_full[rbank] clears and rbank toggles.
  - data_oK are driven from bank[rbank] registers when out_valid=1 and are 0 when out_valid=0.
  - Outputs are held stable while out_valid=1 && out_ready=0.
- Latency:
  - out_valid rises the cycle after the 16th accepted sample of a frame.
  - The first sample of the next frame may be accepted that same cycle.
- Throughput: one sample per cycle sustained while out_ready is asserted at least once per 16 cycles.
- Simultaneous events:
  - Frame completion into one bank and acceptance of the other bank in the same cycle: both take effect.
  - With both banks full, in_ready=0 until an acceptance; the acceptance cycle frees a bank and in_ready=1 the next cycle.
- Overflow: none possible; the handshake is the only flow control and no samples are ever dropped silently.

Optional Feature:
- Macro: FFT16_BITREV_EN.
- Defined: idx(wptr) = bit-reverse of the 4-bit wptr (sample n lands on data_o{rev(n)}), which is what the decimation-in-time butterfly chain expects.
- Undefined: idx(wptr)=wptr (natural order); reordering is the responsibility of downstream wiring.
- Handshake timing is identical in both builds.

Decomposition:
- fft16_pkg holds:
  - constants N=16, LOG2N=4, DW=17;
  - complex word typedef {re,im} of DW signed;
  - the 4-bit bit-reverse function;
  - the bank-state encoding.
- One natural sub-module: fft16_frame_bank, a 16-entry complex register bank with one indexed write port, flat 16-word read, and async clear.
  - Instantiated twice; framer control logic stays in the top.

Test Plan:
- Reset then stream samples re=n, im=-n for n=0..15 continuously, out_ready=1 -> out_valid high on the cycle after n=15.
  - Natural build: data_o5_R=5, data_o5_I=-5.
  - FFT16_BITREV_EN build: data_o10_R=5 and data_o1_R=8.
  - frame_err=0 throughout.
- Stream 48 samples continuously with out_ready=0 -> in_ready falls after sample 31; the first frame is held stable.
  - Raise out_ready for 1 cycle -> rbank toggles and the second frame appears.
  - in_ready=1 on the next cycle and sample 32 is accepted.
- Write 7 samples, then a sample with in_sof=1 and re=100 -> frame_err pulses exactly 1 cycle.
  - 15 more samples complete the frame; data_o0_R=100.
- IN_W=8 with input re=8'h80 -> output data_o0_R=-128 (17'h1FF80), confirming sign-extension.
- Deassert rst_n mid-frame (wptr=9) with one bank full -> out_valid=0 and all data_oK=0 immediately.
  - After release, a fresh 16-sample frame is output correctly.
- Randomly toggle in_valid and out_ready over 1000 frames -> scoreboard shows no loss, duplication or reordering of frames, and outputs never change while out_valid=1 && out_ready=0.
